// File: rtl/volume_meter_hold.sv
// Volume bar-graph level with instant attack, timed decay,
// peak-hold marker and clip indicator.
module volume_meter_hold #(
  parameter int DECAY_CYCLES = 2_500_000,
  parameter int HOLD_CYCLES  = 25_000_000
) (
  input  logic       clk_select,
  input  logic       reset,
  input  logic       vol_0,
  input  logic       vol_1,
  input  logic       vol_2,
  input  logic       vol_3,
  input  logic       vol_4,
  input  logic       vol_5,
  output logic [2:0] level,
  output logic [2:0] peak,
  output logic [5:0] bar_leds,
  output logic       clip
);

  localparam int DW = $clog2(DECAY_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DECAY_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic {
    TRACK,
    HOLD
  } pk_state_t;

  pk_state_t       state;
  logic [2:0]      in_lvl;
  logic [2:0]      rel_lvl;
  logic [DW-1:0]   dcnt;
  logic [HW-1:0]   hcnt;
  logic [HW-1:0]   ccnt;

  always_comb begin
    in_lvl = 3'd0;
    priority case (1'b1)
      vol_5:   in_lvl = 3'd6;
      vol_4:   in_lvl = 3'd5;
      vol_3:   in_lvl = 3'd4;
      vol_2:   in_lvl = 3'd3;
      vol_1:   in_lvl = 3'd2;
      vol_0:   in_lvl = 3'd1;
      default: in_lvl = 3'd0;
    endcase
  end

  // Release target: pre-decrement bar, or a same-cycle attack.
  assign rel_lvl = (in_lvl > level) ? in_lvl : level;

  always_ff @(posedge clk_select) begin
    if (reset) begin
      level <= 3'd0;
      dcnt  <= '0;
    end else if (in_lvl >= level) begin
      level <= in_lvl;
      dcnt  <= '0;
    end else if (dcnt == D_LAST) begin
      level <= level - 3'd1;
      dcnt  <= '0;
    end else begin
      dcnt  <= dcnt + 1'b1;
    end
  end

  always_ff @(posedge clk_select) begin
    if (reset) begin
      state <= TRACK;
      peak  <= 3'd0;
      hcnt  <= '0;
    end else begin
      unique case (state)
        TRACK: begin
          if (in_lvl > peak) begin
            peak  <= in_lvl;
            hcnt  <= '0;
            state <= HOLD;
          end else if (peak != level) begin
            hcnt  <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (in_lvl >= peak) begin
            peak <= in_lvl;
            hcnt <= '0;
          end else if (hcnt == H_LAST) begin
            peak  <= rel_lvl;
            hcnt  <= '0;
            state <= TRACK;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= TRACK;
      endcase
    end
  end

  always_ff @(posedge clk_select) begin
    if (reset) begin
      clip <= 1'b0;
      ccnt <= '0;
    end else if (in_lvl == 3'd6) begin
      clip <= 1'b1;
      ccnt <= '0;
    end else if (clip) begin
      if (ccnt == H_LAST) begin
        clip <= 1'b0;
        ccnt <= '0;
      end else begin
        ccnt <= ccnt + 1'b1;
      end
    end
  end

  always_comb begin
    bar_leds = 6'd0;
    for (int i = 0; i < 6; i++) begin
      bar_leds[i] = (3'(i) < level) |
                    ((peak != 3'd0) && (3'(i) == peak - 3'd1));
    end
  end

endmodule

// File: doc/volume_meter_hold.md
# volume_meter_hold

Downstream stage of the volume detector. Consumes the six one-hot volume flags and produces a display-ready bar-graph level with instant attack, timed per-step decay, and a peak-hold marker. Its output drives the LED bar and the visualizer's bar-height logic. All behaviour is clocked on the same selected clock as the detector.

## Interface

Parameters:
- DECAY_CYCLES, 2_500_000: clock cycles per one-step bar decay. Must be ≥ 1.
- HOLD_CYCLES, 25_000_000: clock cycles the peak marker is held before it releases. Must be ≥ 1.

Ports:
- clk_select  in  1  the single clock. Synchronous, active-high reset and all state use this clock.
- reset  in  1  synchronous, active-high reset.
- vol_0 … vol_5  in  1 each  volume flags from the detector. vol_5 is loudest. Normally one-hot or all-zero.
- level  out  3  current bar height, 0–6.
- peak  out  3  held peak height, 0–6. Always ≥ level.
- bar_leds  out  6  thermometer of level, OR'd with the peak marker.
- clip  out  1  high while a level-6 event is within its hold window.

## Operation

- Input decode (combinational, priority high wins):
  - in_lvl = 6 if vol_5, else 5 if vol_4, … else 1 if vol_0, else 0.
  - If several flags are high, the highest index wins.
- Bar register level and counter dcnt. dcnt has width $clog2(DECAY_CYCLES+1).
  - Attack, when in_lvl > level: level ← in_lvl and dcnt ← 0.
  - Track, when in_lvl == level: level unchanged, dcnt ← 0.
  - Decay, when in_lvl < level:
    - If dcnt == DECAY_CYCLES-1: level ← level-1 and dcnt ← 0.
    - Otherwise dcnt ← dcnt+1.
    - level never goes below in_lvl or below 0.
- Peak register peak and counter hcnt. hcnt has width $clog2(HOLD_CYCLES+1). The peak logic is a two-state FSM:
  - TRACK (peak == level):
    - If in_lvl > peak: peak ← in_lvl, hcnt ← 0, go to HOLD. Otherwise stay.
  - HOLD (peak > level):
    - If in_lvl ≥ peak: peak ← in_lvl and hcnt ← 0.
    - Else if hcnt == HOLD_CYCLES-1: peak ← level (the current registered value), hcnt ← 0, go to TRACK.
    - Otherwise hcnt ← hcnt+1.
- Invariant: peak ≥ level on every cycle. A bench assertion must check it.
- bar_leds[i] = (i < level) | (peak != 0 && i == peak-1), for i = 0…5. It is combinational from the registered level and peak.
- clip and counter ccnt:
  - If in_lvl == 6: clip ← 1 and ccnt ← 0.
  - Else, if clip is high: ccnt increments. At HOLD_CYCLES-1, clip ← 0 and ccnt ← 0.
- Reset: level, peak, clip, dcnt, hcnt and ccnt all clear to 0. The FSM goes to TRACK, so bar_leds = 0.
  - Reset asserted mid-decay or mid-hold aborts the operation immediately.
  - No stale count survives reset.

## Timing

- Latency: a vol_* change is reflected in level, peak and clip at the next rising edge of clk_select (1 cycle). bar_leds follows in the same cycle as level and peak.
- Decay rate: one step per DECAY_CYCLES cycles while the input stays below the bar. Full decay from 6 to 0 with silent input takes 6·DECAY_CYCLES cycles.
- The decay count restarts whenever an attack occurs or the input equals the bar.
- Peak release: HOLD_CYCLES cycles after the last cycle with in_lvl ≥ peak.
- Simultaneous events:
  - Attack and decay expiry in the same cycle: attack wins, dcnt ← 0.
  - New peak and hold expiry in the same cycle: new peak wins, hcnt ← 0.
  - Hold expiry and bar decrement in the same cycle: peak takes the pre-decrement level. On the next cycle peak > level, so the FSM re-enters HOLD.
- Counters never exceed terminal count − 1. With DECAY_CYCLES = 1, the bar decays one step every cycle.

## Test plan

All scenarios use DECAY_CYCLES=4 and HOLD_CYCLES=8.

1. Reset: assert reset for 2 cycles with vol_5=1 → level=0, peak=0, clip=0, bar_leds=000000. After release, the next edge gives level=6, bar_leds=111111, clip=1.
2. Attack/decay:
   - Stimulus: vol_3=1 for 1 cycle, then all zero.
   - Response: level=4 one cycle after the input. It then falls 4→3→2→1→0, one step every 4 cycles, reaching 0 16 cycles after the input went to zero.
3. Peak hold:
   - Stimulus: vol_4=1 for 1 cycle, then vol_0=1 held.
   - Response: level=5 and peak=5, then level decays to 1. peak stays 5 for 8 cycles, then releases to the current level.
   - bar_leds = thermometer of level plus bit 4 set during the hold.
4. Priority and track:
   - vol_1 and vol_3 both high → level=4.
   - Holding vol_3 alone → level stays 4 indefinitely and dcnt stays 0.
5. Simultaneous: with level=3, apply vol_4 on exactly the cycle dcnt=3 → level=5 (not 2) and dcnt=0.
6. Reset mid-operation:
   - Stimulus: reset during HOLD with peak=6 and clip=1.
   - Response: all outputs 0 on the next edge. After release with silent input, everything stays 0.
   - Random one-hot stimulus: peak ≥ level asserted every cycle.
